// File: rtl/rv_pkg.sv
// Shared definitions for the rv_* ready/valid block family: width helpers and
// a handshake bundle type.
package rv_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic valid;
    logic ready;
    logic fire;
  } rv_hs_t;

endpackage

// File: rtl/rv_buffer_mem.sv
// DEPTH x WIDTH register array for rv_buffer: synchronous write, asynchronous
// read. Contents are deliberately not reset.
module rv_buffer_mem
  import rv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [ptr_w(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]          wdata_i,
  input  logic [ptr_w(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]          rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rv_buffer.sv
// Parametrised ready/valid elastic buffer with synchronous flush and registered
// in_ready/out_valid. Optional occupancy port enabled by RV_BUFFER_COUNT_EN.
module rv_buffer
  import rv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef RV_BUFFER_COUNT_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] count
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  rv_hs_t        in_hs, out_hs;

  // Flush suppresses both handshakes so nothing presented that cycle lands.
  always_comb begin
    in_hs.valid  = in_valid;
    in_hs.ready  = in_ready_q;
    in_hs.fire   = in_valid & in_ready_q & ~flush;
    out_hs.valid = out_valid_q;
    out_hs.ready = out_ready;
    out_hs.fire  = out_valid_q & out_ready & ~flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (in_hs.fire) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (out_hs.fire) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      occ_d = occ_q + CW'(in_hs.fire) - CW'(out_hs.fire);
    end
    in_ready_d  = (occ_d != FULL);
    out_valid_d = (occ_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  rv_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (in_hs.fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

`ifdef RV_BUFFER_COUNT_EN
  assign count = occ_q;
`endif

endmodule

// File: tb/tb_rv_buffer.sv
// Self-checking bench for rv_buffer (DEPTH=4, WIDTH=8): directed vector table,
// hand-written corner sequences and a randomized run against a queue model.
module tb_rv_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef RV_BUFFER_COUNT_EN
  logic [CW-1:0]    count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef RV_BUFFER_COUNT_EN
    ,
    .count     (count)
`endif
  );

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic       chk_d;
    logic [7:0] e_d;
    int         e_cnt;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic fl, input logic iv, input logic [7:0] d, input logic ordy,
                     input logic e_ir, input logic e_ov, input logic chk_d,
                     input logic [7:0] e_d, input int e_cnt);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.chk_d = chk_d; v.e_d = e_d; v.e_cnt = e_cnt;
    vt.push_back(v);
  endtask

  task automatic check_count(input string name, input int exp);
`ifdef RV_BUFFER_COUNT_EN
    check(name, 32'(count), 32'(exp));
`else
    if (exp < 0) $display("bad expected count in %s", name);
`endif
  endtask

  logic [7:0] model_q[$];
  logic [7:0] pp_exp[8];

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // ---- reset ----
    tick(); tick();
    check("rst_held_in_ready", 32'(in_ready), 32'd1);
    check("rst_held_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    tick();
    check("rst_rel_in_ready", 32'(in_ready), 32'd1);
    check("rst_rel_out_valid", 32'(out_valid), 32'd0);
    check_count("rst_rel_count", 0);

    // ---- directed table: fill, overfill, drain, flush ----
    //   fl iv  d     ordy ir ov chk  e_d   cnt
    add(0, 1, 8'h11, 0,  1, 1, 1, 8'h11, 1);
    add(0, 1, 8'h22, 0,  1, 1, 1, 8'h11, 2);
    add(0, 1, 8'h33, 0,  1, 1, 1, 8'h11, 3);
    add(0, 1, 8'h44, 0,  0, 1, 1, 8'h11, 4);
    add(0, 1, 8'h55, 0,  0, 1, 1, 8'h11, 4);
    add(0, 1, 8'h66, 1,  1, 1, 1, 8'h22, 3);
    add(0, 0, 8'h00, 1,  1, 1, 1, 8'h33, 2);
    add(0, 0, 8'h00, 1,  1, 1, 1, 8'h44, 1);
    add(0, 0, 8'h00, 1,  1, 0, 0, 8'h00, 0);
    add(0, 1, 8'h01, 0,  1, 1, 1, 8'h01, 1);
    add(0, 1, 8'h02, 0,  1, 1, 1, 8'h01, 2);
    add(0, 1, 8'h03, 0,  1, 1, 1, 8'h01, 3);
    add(1, 1, 8'h77, 1,  1, 0, 0, 8'h00, 0);
    add(0, 1, 8'h88, 0,  1, 1, 1, 8'h88, 1);
    add(0, 0, 8'h00, 1,  1, 0, 0, 8'h00, 0);
    for (int i = 0; i < vt.size(); i++) begin
      flush = vt[i].fl; in_valid = vt[i].iv; in_data = vt[i].d; out_ready = vt[i].ordy;
      tick();
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      if (vt[i].chk_d) check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vt[i].e_d));
      check_count($sformatf("vec%0d_count", i), vt[i].e_cnt);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // ---- simultaneous push/pop at occ=2, pointers wrap twice ----
    in_valid = 1'b1; in_data = 8'hB0; tick();
    in_data = 8'hB1; tick();
    pp_exp[0] = 8'hB0; pp_exp[1] = 8'hB1;
    for (int i = 0; i < 6; i++) pp_exp[i+2] = 8'(8'hA0 + i);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp%0d_out_data", i), 32'(out_data), 32'(pp_exp[i]));
      in_valid = 1'b1; out_ready = 1'b1; in_data = 8'(8'hA0 + i);
      tick();
      check($sformatf("pp%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("pp%0d_in_ready", i), 32'(in_ready), 32'd1);
      check_count($sformatf("pp%0d_count", i), 2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_tail_out_data", 32'(out_data), 32'hA6);

    // ---- async reset mid-transfer (occ=2) ----
    #3 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check_count("arst_count", 0);
    #2 rst = 1'b1;
    tick();
    check("arst_rel_out_valid", 32'(out_valid), 32'd0);
    check("arst_rel_in_ready", 32'(in_ready), 32'd1);

    // ---- randomized run against queue model ----
    model_q.delete();
    for (int n = 0; n < 600; n++) begin
      logic mpush, mpop;
      flush     = ($urandom_range(15) == 0);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_data   = 8'($urandom);
      mpush = in_valid && (model_q.size() < DEPTH);
      mpop  = out_ready && (model_q.size() > 0);
      tick();
      if (flush) begin
        model_q.delete();
      end else begin
        if (mpop) void'(model_q.pop_front());
        if (mpush) model_q.push_back(in_data);
      end
      check("rnd_in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
      check("rnd_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      if (model_q.size() > 0) check("rnd_out_data", 32'(out_data), 32'(model_q[0]));
      check_count("rnd_count", model_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
